// File: rtl/tipi_pkg.sv
// ---------------------------------------------------------------------------
// tipi_pkg
// Shared constants for the TIPI PEB card logic.
//
// Contents:
//   NBITS         number of latched CRU output bits on the card (fixed at 4)
//   CRU_SPACE     value that the top nibble of the TI address (A0..A3) must
//                 carry for a CRU access to belong to the card area
//   CRU_BIT_*     bit numbers of the individual CRU bits, as used by the
//                 card's enable/control logic
//   cruHit()      helper that performs the CRU address decode
// ---------------------------------------------------------------------------
package tipi_pkg;

    localparam int unsigned NBITS = 4;

    localparam logic [0:3] CRU_SPACE = 4'b0010;

    // Bit 0 enables the card ROM; the remaining bits feed other control
    // logic on the card and are named by position only.
    localparam int unsigned CRU_BIT_ROMEN = 0;
    localparam int unsigned CRU_BIT_1     = 1;
    localparam int unsigned CRU_BIT_2     = 2;
    localparam int unsigned CRU_BIT_3     = 3;

    // The card answers only when A0..A3 point at CRU space, A4..A7 match
    // the jumpered base, and A8..A12 are all zero. The last condition is
    // what keeps bit numbers above 3 from aliasing onto the four real bits.
    function automatic logic cruHit(input logic [0:14] address,
                                    input logic [0:3]  base);
        return (address[0:3] == CRU_SPACE) &&
               (address[4:7] == base) &&
               (address[8:12] == 5'b00000);
    endfunction

endpackage

// File: rtl/cru_bits.sv
// ---------------------------------------------------------------------------
// cru_bits
// Four-bit CRU output latch for the TIPI PEB card on the TI-99/4A CRU bus.
// The CPU writes single bits with LDCR/SBO/SBZ (strobed by CRUCLK) and reads
// them back with TB/STCR. All buses use TI bit numbering: index 0 is the MSB.
//
// Ports:
//   ti_cru_clk  in   1   CRU write strobe, rising edge latches a bit
//   ti_reset_n  in   1   asynchronous active-low reset, clears all bits
//   cru_base    in   4   card base select, compared with addr[4:7]
//   ti_memen    in   1   TI memory enable, active low (high = no memory cycle)
//   ti_ph3      in   1   TI phase-3 clock, not used by this block
//   addr        in   15  TI address bus A0..A14, addr[0] is the MSB
//   ti_cru_out  in   1   CRU data from the CPU
//   ti_cru_in   out  1   CRU read data to the CPU
//   bits        out  4   latched CRU bits, bits[0] is CRU bit 0 (ROM enable)
// ---------------------------------------------------------------------------
module cru_bits
    import tipi_pkg::*;
(
    input  logic             ti_cru_clk,
    input  logic             ti_reset_n,
    input  logic [0:3]       cru_base,
    input  logic             ti_memen,
    input  logic             ti_ph3,
    input  logic [0:14]      addr,
    input  logic             ti_cru_out,
    output logic             ti_cru_in,
    output logic [0:NBITS-1] bits
);

    logic             w_sel;
    logic [1:0]       w_idx;
    logic [0:NBITS-1] r_bits;
    logic             w_unused_ph3;

    // Address decode is purely combinational so that a change of the base
    // jumpers applies to the very next access.
    assign w_sel = cruHit(addr, cru_base);
    assign w_idx = addr[13:14];

    // ti_ph3 is part of the card connector but plays no role here.
    assign w_unused_ph3 = ti_ph3;

    // Bit latch. Reset is asynchronous and wins over a coincident CRUCLK
    // edge. CRUCLK only pulses during CRU cycles, so memory enable is not
    // needed to qualify a write; only the address decode gates it.
    always_ff @(posedge ti_cru_clk or negedge ti_reset_n) begin
        if (!ti_reset_n) begin
            r_bits <= '0;
        end else if (w_sel) begin
            r_bits[w_idx] <= ti_cru_out;
        end
    end

    // Read-back is driven only while the card is addressed and no memory
    // cycle is in progress; otherwise the card contributes a zero.
    assign ti_cru_in = (w_sel && ti_memen) ? r_bits[w_idx] : 1'b0;

    assign bits = r_bits;

endmodule

// File: tb/tb_cru_bits.sv
// ---------------------------------------------------------------------------
// tb_cru_bits
// Directed test bench for cru_bits. Expected values are hand computed using
// TI bit numbering (A0 is the MSB of the 15-bit address, bits[0] is the MSB
// of the 4-bit output). With that numbering a card at base 2 sits at
// 15'h1100..15'h1103 and a card at base 0 at 15'h1000..15'h1003.
// ---------------------------------------------------------------------------
module tb_cru_bits;

    logic        tiCruClk;
    logic        tiResetN;
    logic [0:3]  cruBase;
    logic        tiMemen;
    logic        tiPh3;
    logic [0:14] addr;
    logic        tiCruOut;
    logic        tiCruIn;
    logic [0:3]  bits;

    int vectorCount;
    int missCount;

    cru_bits dut (
        .ti_cru_clk (tiCruClk),
        .ti_reset_n (tiResetN),
        .cru_base   (cruBase),
        .ti_memen   (tiMemen),
        .ti_ph3     (tiPh3),
        .addr       (addr),
        .ti_cru_out (tiCruOut),
        .ti_cru_in  (tiCruIn),
        .bits       (bits)
    );

    // Free-running phase-3 clock; the DUT ignores it but it keeps the
    // input toggling like on the real bus.
    initial begin
        tiPh3 = 1'b0;
        forever #7 tiPh3 = ~tiPh3;
    end

    // Single comparison point: counts the vector and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // One CRU write: set address and data, then one CRUCLK pulse. Outputs
    // are sampled afterwards, well away from the rising edge.
    task automatic applyStimulus(input logic [0:14] a, input logic d);
        addr     = a;
        tiCruOut = d;
        #5 tiCruClk = 1'b1;
        #5 tiCruClk = 1'b0;
        #5;
    endtask

    // Combinational read: set address and memory enable, settle, sample.
    task automatic readBit(input logic [0:14] a, input logic memen,
                           input string tag, input logic expected);
        addr    = a;
        tiMemen = memen;
        #2;
        checkOutput(tag, {3'b000, tiCruIn}, {3'b000, expected});
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        tiCruClk    = 1'b0;
        tiResetN    = 1'b0;
        cruBase     = 4'h0;
        tiMemen     = 1'b1;
        addr        = 15'h1000;
        tiCruOut    = 1'b0;

        // Reset only, no clocks
        #10;
        checkOutput("reset_bits", bits, 4'b0000);
        checkOutput("reset_cru_in", {3'b000, tiCruIn}, 4'b0000);
        tiResetN = 1'b1;
        #5;

        // Base 0 writes to bit 0 and bit 3
        applyStimulus(15'h1000, 1'b1);
        checkOutput("wr_b0_base0", bits, 4'b1000);
        applyStimulus(15'h1003, 1'b1);
        checkOutput("wr_b3_base0", bits, 4'b1001);
        readBit(15'h1003, 1'b1, "rd_b3_memen1", 1'b1);
        readBit(15'h1001, 1'b1, "rd_b1_memen1", 1'b0);
        readBit(15'h1003, 1'b0, "rd_b3_memen0", 1'b0);

        // Switch base to 2: the old address no longer hits
        cruBase = 4'h2;
        tiMemen = 1'b1;
        applyStimulus(15'h1000, 1'b1);
        checkOutput("wr_wrong_base", bits, 4'b1001);
        readBit(15'h1000, 1'b1, "rd_wrong_base_b0", 1'b0);
        readBit(15'h1003, 1'b1, "rd_wrong_base_b3", 1'b0);

        // Fill all bits at base 2, then clear bit 1
        for (int i = 0; i < 4; i++) begin
            logic [0:14] a;
            a = 15'h1100 + 15'(i);
            applyStimulus(a, 1'b1);
        end
        checkOutput("fill_all_base2", bits, 4'b1111);
        applyStimulus(15'h1101, 1'b0);
        checkOutput("clr_b1_base2", bits, 4'b1011);
        readBit(15'h1101, 1'b0, "rd_b1_memen0", 1'b0);
        readBit(15'h1100, 1'b1, "rd_b0_memen1", 1'b1);
        readBit(15'h1100, 1'b0, "rd_b0_memen0", 1'b0);

        // Bit number above 3 (A11 set) must not alias onto bit 0
        applyStimulus(15'h1108, 1'b0);
        checkOutput("wr_idx_above3", bits, 4'b1011);
        readBit(15'h1108, 1'b1, "rd_idx_above3", 1'b0);

        // Wrong CRU space nibble must not hit either
        applyStimulus(15'h3101, 1'b1);
        checkOutput("wr_wrong_space", bits, 4'b1011);

        // Idempotent rewrite of an existing value
        applyStimulus(15'h1102, 1'b1);
        checkOutput("rewrite_same", bits, 4'b1011);

        // Base change applies combinationally to reads
        cruBase = 4'h0;
        readBit(15'h1000, 1'b1, "rd_base_swap_hit", 1'b1);
        readBit(15'h1100, 1'b1, "rd_base_swap_miss", 1'b0);
        cruBase = 4'h2;

        // Bring all bits to 1, then reset while CRUCLK is high
        applyStimulus(15'h1101, 1'b1);
        checkOutput("refill_base2", bits, 4'b1111);
        addr     = 15'h1100;
        tiCruOut = 1'b1;
        #5 tiCruClk = 1'b1;
        #2 tiResetN = 1'b0;
        #1;
        checkOutput("reset_mid_high", bits, 4'b0000);
        #4 tiCruClk = 1'b0;
        #5;

        // Clock edges during reset do nothing
        applyStimulus(15'h1100, 1'b1);
        checkOutput("clk_during_reset", bits, 4'b0000);

        // Release reset; the next edge writes normally
        tiResetN = 1'b1;
        #5;
        checkOutput("after_release", bits, 4'b0000);
        applyStimulus(15'h1102, 1'b1);
        checkOutput("first_wr_after_rst", bits, 4'b0010);
        readBit(15'h1102, 1'b1, "rd_b2_after_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
